// File: rtl/whac_pkg.sv
// Shared constants for the whack-a-mole hit scorer.
//   DEF_NUM_HOLES      : default number of holes, switches and LEDs
//   DEF_DEBOUNCE_DELAY : default stable cycles needed to accept a switch change
//   DEF_STREAK_WIDTH   : default width of the streak and miss counters
package whac_pkg;

    localparam int DEF_NUM_HOLES      = 6;
    localparam int DEF_DEBOUNCE_DELAY = 2500;
    localparam int DEF_STREAK_WIDTH   = 8;

    // Counter width able to hold values 0..max_value (never less than 1 bit).
    function automatic int count_width(input int max_value);
        return (max_value > 1) ? $clog2(max_value + 1) : 1;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One-bit switch conditioner: 2-flop synchroniser followed by a debouncer.
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   raw       : asynchronous switch input
//   debounced : accepted switch level; flips only after the synchronised
//               level has differed from it for DEBOUNCE_DELAY cycles in a row
module switch_debouncer
    import whac_pkg::*;
#(
    parameter int DEBOUNCE_DELAY = DEF_DEBOUNCE_DELAY
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic debounced
);

    localparam int CW = count_width(DEBOUNCE_DELAY - 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_DELAY - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          deb_r;
    logic [CW-1:0] cnt_r;

    // Synchronise the raw switch, then count consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r != deb_r) begin
                // The cycle that reaches the count is itself the last stable one.
                if (cnt_r == LAST) begin
                    deb_r <= sync2_r;
                    cnt_r <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end

    assign debounced = deb_r;

endmodule

// File: rtl/hit_scorer.sv
// Whack-a-mole hit scorer: debounces the player switches, tracks live moles
// and scores hits, misses, streak and miss total.
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   switches           : raw player switches (any debounced change is a whack)
//   mole_positions     : 1 = mole up in that hole
//   game_in_progress   : enables scoring; rising edge restarts the game
//   LEDs               : live, unhit moles
//   miss               : pulse on a whack-miss or expiry-miss
//   non_full_clear_hit : pulse on a hit leaving at least one live mole
//   full_clear_hit     : pulse on a hit leaving no live moles
//   hit_count          : holes hit this cycle (0 when no hit pulse)
//   streak, miss_total : saturating hit streak and miss counter
module hit_scorer
    import whac_pkg::*;
#(
    parameter int NUM_HOLES      = DEF_NUM_HOLES,
    parameter int DEBOUNCE_DELAY = DEF_DEBOUNCE_DELAY,
    parameter int STREAK_WIDTH   = DEF_STREAK_WIDTH,
    parameter int EXPIRY_MISS    = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_HOLES-1:0]           switches,
    input  logic [NUM_HOLES-1:0]           mole_positions,
    input  logic                           game_in_progress,
    output logic [NUM_HOLES-1:0]           LEDs,
    output logic                           miss,
    output logic                           non_full_clear_hit,
    output logic                           full_clear_hit,
    output logic [$clog2(NUM_HOLES+1)-1:0] hit_count,
    output logic [STREAK_WIDTH-1:0]        streak,
    output logic [STREAK_WIDTH-1:0]        miss_total
);

    localparam int CW = $clog2(NUM_HOLES + 1);

    function automatic logic [CW-1:0] popcount(input logic [NUM_HOLES-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < NUM_HOLES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    logic [NUM_HOLES-1:0]    deb_s;
    logic [NUM_HOLES-1:0]    base_r;
    logic [NUM_HOLES-1:0]    mole_prev_r;
    logic                    game_prev_r;
    logic [NUM_HOLES-1:0]    alive_r;
    logic                    miss_r;
    logic                    nfc_r;
    logic                    fc_r;
    logic [CW-1:0]           hc_r;
    logic [STREAK_WIDTH-1:0] streak_r;
    logic [STREAK_WIDTH-1:0] mt_r;

    logic                    start_s;
    logic [NUM_HOLES-1:0]    whack_s;
    logic [NUM_HOLES-1:0]    hit_s;
    logic [NUM_HOLES-1:0]    expiry_s;
    logic [NUM_HOLES-1:0]    alive_next_s;
    logic                    any_hit_s;
    logic                    any_miss_s;
    logic [CW-1:0]           count_s;
    logic [STREAK_WIDTH:0]   streak_sum_s;
    logic [STREAK_WIDTH-1:0] streak_sat_s;

    for (genvar g = 0; g < NUM_HOLES; g++) begin : g_deb
        switch_debouncer #(.DEBOUNCE_DELAY(DEBOUNCE_DELAY)) u_deb (
            .clk       (clk),
            .reset     (reset),
            .raw       (switches[g]),
            .debounced (deb_s[g])
        );
    end

    // Hit / miss classification and next alive state.
    always_comb begin
        start_s      = game_in_progress & ~game_prev_r;
        // base_r follows the debounced bits every cycle, so changes made
        // while the game is off never turn into whacks later.
        whack_s      = deb_s ^ base_r;
        hit_s        = whack_s & alive_r;
        if (EXPIRY_MISS != 0) begin
            expiry_s = alive_r & ~mole_positions & ~hit_s;
        end else begin
            expiry_s = {NUM_HOLES{1'b0}};
        end
        alive_next_s = (alive_r | (mole_positions & ~mole_prev_r)) & mole_positions & ~hit_s;
        any_hit_s    = |hit_s;
        any_miss_s   = |(whack_s & ~alive_r) | (|expiry_s);
        count_s      = popcount(hit_s);
        streak_sum_s = {1'b0, streak_r} + (STREAK_WIDTH+1)'(count_s);
        if (streak_sum_s[STREAK_WIDTH]) begin
            streak_sat_s = {STREAK_WIDTH{1'b1}};
        end else begin
            streak_sat_s = streak_sum_s[STREAK_WIDTH-1:0];
        end
    end

    // Scoring state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r      <= {NUM_HOLES{1'b0}};
            mole_prev_r <= {NUM_HOLES{1'b0}};
            game_prev_r <= 1'b0;
            alive_r     <= {NUM_HOLES{1'b0}};
            miss_r      <= 1'b0;
            nfc_r       <= 1'b0;
            fc_r        <= 1'b0;
            hc_r        <= {CW{1'b0}};
            streak_r    <= {STREAK_WIDTH{1'b0}};
            mt_r        <= {STREAK_WIDTH{1'b0}};
        end else begin
            base_r      <= deb_s;
            mole_prev_r <= mole_positions;
            game_prev_r <= game_in_progress;
            if (!game_in_progress) begin
                alive_r <= {NUM_HOLES{1'b0}};
                miss_r  <= 1'b0;
                nfc_r   <= 1'b0;
                fc_r    <= 1'b0;
                hc_r    <= {CW{1'b0}};
            end else if (start_s) begin
                alive_r  <= mole_positions;
                miss_r   <= 1'b0;
                nfc_r    <= 1'b0;
                fc_r     <= 1'b0;
                hc_r     <= {CW{1'b0}};
                streak_r <= {STREAK_WIDTH{1'b0}};
                mt_r     <= {STREAK_WIDTH{1'b0}};
            end else begin
                alive_r <= alive_next_s;
                miss_r  <= any_miss_s;
                nfc_r   <= any_hit_s & (|alive_next_s);
                fc_r    <= any_hit_s & ~(|alive_next_s);
                hc_r    <= any_hit_s ? count_s : {CW{1'b0}};
                if (any_miss_s) begin
                    streak_r <= {STREAK_WIDTH{1'b0}};
                end else if (any_hit_s) begin
                    streak_r <= streak_sat_s;
                end else begin
                    streak_r <= streak_r;
                end
                if (any_miss_s && (mt_r != {STREAK_WIDTH{1'b1}})) begin
                    mt_r <= mt_r + STREAK_WIDTH'(1);
                end else begin
                    mt_r <= mt_r;
                end
            end
        end
    end

    assign LEDs               = alive_r;
    assign miss               = miss_r;
    assign non_full_clear_hit = nfc_r;
    assign full_clear_hit     = fc_r;
    assign hit_count          = hc_r;
    assign streak             = streak_r;
    assign miss_total         = mt_r;

endmodule

// File: tb/tb_hit_scorer.sv
// Directed bench for hit_scorer (NUM_HOLES=6, DEBOUNCE_DELAY=2). A second
// instance with EXPIRY_MISS=0 shares the stimulus to cover expiry handling.
module tb_hit_scorer;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] switches;
    logic [5:0] mole_positions;
    logic       game_in_progress;

    logic [5:0] leds0, leds1;
    logic       miss0, miss1, nfc0, nfc1, fc0, fc1;
    logic [2:0] hc0, hc1;
    logic [7:0] streak0, streak1, mt0, mt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hit_scorer #(.NUM_HOLES(6), .DEBOUNCE_DELAY(2), .STREAK_WIDTH(8), .EXPIRY_MISS(1)) dut0 (
        .clk(clk), .reset(reset), .switches(switches), .mole_positions(mole_positions),
        .game_in_progress(game_in_progress), .LEDs(leds0), .miss(miss0),
        .non_full_clear_hit(nfc0), .full_clear_hit(fc0), .hit_count(hc0),
        .streak(streak0), .miss_total(mt0)
    );

    hit_scorer #(.NUM_HOLES(6), .DEBOUNCE_DELAY(2), .STREAK_WIDTH(8), .EXPIRY_MISS(0)) dut1 (
        .clk(clk), .reset(reset), .switches(switches), .mole_positions(mole_positions),
        .game_in_progress(game_in_progress), .LEDs(leds1), .miss(miss1),
        .non_full_clear_hit(nfc1), .full_clear_hit(fc1), .hit_count(hc1),
        .streak(streak1), .miss_total(mt1)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step n cycles, requiring no pulse on dut0 in any of them.
    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk(tag, 32'({miss0, nfc0, fc0, hc0}), 32'd0);
        end
    endtask

    initial begin
        reset            = 1'b1;
        switches         = 6'b000000;
        mole_positions   = 6'b000000;
        game_in_progress = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        chk("reset_leds",   32'(leds0),   32'd0);
        chk("reset_pulses", 32'({miss0, nfc0, fc0}), 32'd0);
        chk("reset_hc",     32'(hc0),     32'd0);
        chk("reset_streak", 32'(streak0), 32'd0);
        chk("reset_mt",     32'(mt0),     32'd0);

        // Game off: everything stays idle while switches move.
        mole_positions = 6'b101000;
        switches       = 6'b111111;
        quiet("off_quiet_a", 8);
        chk("off_leds", 32'(leds0), 32'd0);
        switches = 6'b000000;
        quiet("off_quiet_b", 8);
        chk("off_counters", 32'({streak0, mt0}), 32'd0);

        // Game start loads live moles.
        game_in_progress = 1'b1;
        step(1);
        chk("start_leds", 32'(leds0), 32'h28);
        chk("start_nopulse", 32'({miss0, nfc0, fc0}), 32'd0);

        // Hit on hole 5: pulse exactly 5 cycles after the switch change.
        switches = 6'b100000;
        step(4);
        chk("hit_early", 32'(nfc0), 32'd0);
        step(1);
        chk("hit_nfc",    32'(nfc0),    32'd1);
        chk("hit_fc",     32'(fc0),     32'd0);
        chk("hit_hc",     32'(hc0),     32'd1);
        chk("hit_streak", 32'(streak0), 32'd1);
        chk("hit_leds",   32'(leds0),   32'h08);
        step(1);
        chk("hit_oneshot", 32'({nfc0, hc0}), 32'd0);

        // Whack on empty hole 4 -> miss.
        switches = 6'b110000;
        step(4);
        chk("miss_early", 32'(miss0), 32'd0);
        step(1);
        chk("miss_pulse",  32'(miss0),   32'd1);
        chk("miss_nohit",  32'({nfc0, fc0}), 32'd0);
        chk("miss_streak", 32'(streak0), 32'd0);
        chk("miss_total",  32'(mt0),     32'd1);

        // Hit the last live mole -> full clear.
        switches = 6'b111000;
        step(5);
        chk("fc_pulse",  32'(fc0),     32'd1);
        chk("fc_nfc",    32'(nfc0),    32'd0);
        chk("fc_hc",     32'(hc0),     32'd1);
        chk("fc_leds",   32'(leds0),   32'd0);
        chk("fc_streak", 32'(streak0), 32'd1);

        // Moles 5 and 4 rise; one switch change hits 5 and misses on 3.
        mole_positions = 6'b000000;
        step(1);
        mole_positions = 6'b110000;
        step(1);
        chk("mix_leds_pre", 32'(leds0), 32'h30);
        switches = 6'b010000;
        step(5);
        chk("mix_nfc",    32'(nfc0),    32'd1);
        chk("mix_miss",   32'(miss0),   32'd1);
        chk("mix_hc",     32'(hc0),     32'd1);
        chk("mix_streak", 32'(streak0), 32'd0);
        chk("mix_mt",     32'(mt0),     32'd2);
        chk("mix_leds",   32'(leds0),   32'h10);

        // Unhit mole 4 drops: expiry-miss only with EXPIRY_MISS=1.
        mole_positions = 6'b000000;
        step(1);
        chk("exp_miss",    32'(miss0), 32'd1);
        chk("exp_mt",      32'(mt0),   32'd3);
        chk("exp_leds",    32'(leds0), 32'd0);
        chk("exp_off_miss", 32'(miss1), 32'd0);
        chk("exp_off_mt",  32'(mt1),   32'd2);
        step(1);
        chk("exp_oneshot", 32'(miss0), 32'd0);

        // A one-cycle bounce on hole 0 is rejected.
        mole_positions = 6'b000001;
        step(1);
        chk("bounce_leds_pre", 32'(leds0), 32'h01);
        switches = 6'b010001;
        step(1);
        switches = 6'b010000;
        quiet("bounce_quiet", 10);
        chk("bounce_leds", 32'(leds0), 32'h01);
        chk("bounce_mt",   32'(mt0),   32'd3);

        // Reset while hole 0 is mid-debounce abandons the pending whack.
        switches = 6'b010001;
        step(2);
        reset    = 1'b1;
        switches = 6'b000000;
        step(1);
        chk("rst_leds",   32'(leds0), 32'd0);
        chk("rst_pulses", 32'({miss0, nfc0, fc0, hc0}), 32'd0);
        chk("rst_counts", 32'({streak0, mt0}), 32'd0);
        step(2);
        reset = 1'b0;
        step(1);
        chk("rst_first", 32'({miss0, nfc0, fc0}), 32'd0);
        quiet("rst_quiet", 10);
        chk("rst_leds_after", 32'(leds0), 32'h01);
        chk("rst_mt_after",   32'(mt0),   32'd0);

        // Game off clears live moles.
        game_in_progress = 1'b0;
        step(1);
        chk("end_leds", 32'(leds0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
